bcd_step_counter: RTL and testbench

Upstream value source for the 4-digit seven-segment display path. Holds a 4-digit packed-BCD count, stepped up or down by two debounced push-buttons, and presents it on `q[15:0]` together with the digit-scan strobe `clk_div` that the seven-segment driver consumes. One instance feeds one driver directly; no glue logic between them.

---
 rtl/bcd_step_counter.sv | 139 +++++++++++++
 tb/tb_bcd_step_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_counter.sv
// bcd_step_counter: 4-digit BCD up/down count from two debounced buttons, plus scan-strobe divider; HOLD_REPEAT_EN adds hold-to-repeat
module bcd_step_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIV_HALF        = 2,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        clr,
    output logic [15:0] q,
    output logic        clk_div,
    output logic        ovf
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    if (DEBOUNCE_CYCLES < 2 || DIV_HALF < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("bcd_step_counter: illegal parameter value");
    end

    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_q;
    logic [1:0]    step;
    logic [CW-1:0] dcnt [2];
    logic [DW-1:0] div_cnt;
    logic [15:0]   q_inc;
    logic [15:0]   q_dec;
    logic          carry;
    logic          borrow;

    assign raw = {btn_down, btn_up};

    // synchronize raw buttons, debounce them, and keep last debounced level for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CW'(DEBOUNCE_CYCLES)) begin
                    lvl[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RW-1:0] rcnt [2];
    logic [1:0]    rep;

    // hold timers run while the debounced level is high, folding back to REPEAT_DELAY every period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!lvl[i] || clr) rcnt[i] <= '0;
                else if (rcnt[i] == RW'(REPEAT_DELAY + REPEAT_PERIOD - 1)) rcnt[i] <= RW'(REPEAT_DELAY);
                else rcnt[i] <= rcnt[i] + RW'(1);
            end
        end
    end

    // a repeat step fires each time a held timer lands on REPEAT_DELAY
    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) rep[i] = lvl[i] && (rcnt[i] == RW'(REPEAT_DELAY));
    end

    assign step = (lvl & ~lvl_q) | rep;
`else
    assign step = lvl & ~lvl_q;
`endif

    // per-digit ripple increment and decrement; carry/borrow out of the top digit marks a wrap
    always_comb begin
        q_inc  = q;
        q_dec  = q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_inc[4*i +: 4] = carry  ? ((q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1) : q[4*i +: 4];
            q_dec[4*i +: 4] = borrow ? ((q[4*i +: 4] == 4'd0) ? 4'd9 : q[4*i +: 4] - 4'd1) : q[4*i +: 4];
            carry  = carry  && (q[4*i +: 4] == 4'd9);
            borrow = borrow && (q[4*i +: 4] == 4'd0);
        end
    end

    // count register: clear wins, opposing steps cancel, otherwise a single BCD step with wrap pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (clr) begin
                q <= '0;
            end else if (step == 2'b01) begin
                q   <= q_inc;
                ovf <= carry;
            end else if (step == 2'b10) begin
                q   <= q_dec;
                ovf <= borrow;
            end
        end
    end

    // free-running divider toggling the scan strobe every DIV_HALF cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_cnt == DW'(DIV_HALF - 1)) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end
endmodule

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter: directed self-checking bench for bcd_step_counter
module tb_bcd_step_counter;
`ifdef HOLD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up;
    logic        btn_down;
    logic        clr;
    logic [15:0] q;
    logic        clk_div;
    logic        ovf;
    int          checks = 0;
    int          errors = 0;

    bcd_step_counter #(
        .DEBOUNCE_CYCLES(4),
        .DIV_HALF(2),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .clr(clr),
        .q(q),
        .clk_div(clk_div),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic press(input logic dn, output int ovf_n);
        ovf_n = 0;
        if (dn) btn_down = 1'b1;
        else btn_up = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 5) begin
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
            ovf_n += int'(ovf);
        end
    endtask

    task automatic do_clr;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        checks += 3;
        if (q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h expected 0000", q); end
        if (clk_div !== 1'b0) begin errors++; $display("FAIL reset_div: got %b expected 0", clk_div); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (clk_div !== 1'b0) begin errors++; $display("FAIL div_first_low: got %b expected 0", clk_div); end
        @(negedge clk);
        checks++;
        if (clk_div !== 1'b1) begin errors++; $display("FAIL div_first_rise: got %b expected 1", clk_div); end
    endtask

    task automatic test_debounce;
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (q !== 16'h0000) begin errors++; $display("FAIL glitch: got %h expected 0000", q); end
        btn_up = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (q !== 16'h0000) begin errors++; $display("FAIL deb_early: got %h expected 0000", q); end
            end
            if (k == 7) begin
                checks++;
                if (q !== 16'h0001) begin errors++; $display("FAIL deb_edge: got %h expected 0001", q); end
            end
            if (k == 13) begin
                checks++;
                if (q !== 16'h0001) begin errors++; $display("FAIL deb_once: got %h expected 0001", q); end
            end
        end
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (q !== (REP ? 16'h0004 : 16'h0001))
            begin errors++; $display("FAIL deb_hold: got %h expected %h", q, REP ? 16'h0004 : 16'h0001); end
    endtask

    task automatic test_wrap;
        int n;
        int tot;
        do_clr();
        checks++;
        if (q !== 16'h0000) begin errors++; $display("FAIL clr_zero: got %h expected 0000", q); end
        press(1'b1, n);
        checks += 2;
        if (q !== 16'h9999) begin errors++; $display("FAIL wrap_down: got %h expected 9999", q); end
        if (n != 1) begin errors++; $display("FAIL wrap_down_ovf: got %0d pulses expected 1", n); end
        press(1'b0, n);
        checks += 2;
        if (q !== 16'h0000) begin errors++; $display("FAIL wrap_up: got %h expected 0000", q); end
        if (n != 1) begin errors++; $display("FAIL wrap_up_ovf: got %0d pulses expected 1", n); end
        tot = 0;
        for (int i = 0; i < 99; i++) begin
            press(1'b0, n);
            tot += n;
        end
        checks += 2;
        if (q !== 16'h0099) begin errors++; $display("FAIL count_99: got %h expected 0099", q); end
        if (tot != 0) begin errors++; $display("FAIL count_99_ovf: got %0d pulses expected 0", tot); end
        press(1'b0, n);
        checks += 2;
        if (q !== 16'h0100) begin errors++; $display("FAIL carry_100: got %h expected 0100", q); end
        if (n != 0) begin errors++; $display("FAIL carry_100_ovf: got %0d pulses expected 0", n); end
    endtask

    task automatic test_conflict;
        int n;
        do_clr();
        for (int i = 0; i < 42; i++) press(1'b0, n);
        checks++;
        if (q !== 16'h0042) begin errors++; $display("FAIL preload_42: got %h expected 0042", q); end
        btn_down = 1'b1;
        press(1'b0, n);
        checks += 2;
        if (q !== 16'h0042) begin errors++; $display("FAIL both_cancel: got %h expected 0042", q); end
        if (n != 0) begin errors++; $display("FAIL both_ovf: got %0d pulses expected 0", n); end
        n = 0;
        btn_up = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 5) btn_up = 1'b0;
            if (k == 6) clr = 1'b1;
            if (k == 7) clr = 1'b0;
            n += int'(ovf);
        end
        checks += 2;
        if (q !== 16'h0000) begin errors++; $display("FAIL clr_wins: got %h expected 0000", q); end
        if (n != 0) begin errors++; $display("FAIL clr_ovf: got %0d pulses expected 0", n); end
    endtask

    task automatic test_repeat;
        do_clr();
        btn_up = 1'b1;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            if (k == 29) btn_up = 1'b0;
            if (k == 15) begin
                checks++;
                if (q !== (REP ? 16'h0002 : 16'h0001))
                    begin errors++; $display("FAIL rep_first: got %h expected %h", q, REP ? 16'h0002 : 16'h0001); end
            end
        end
        checks++;
        if (q !== (REP ? 16'h0007 : 16'h0001))
            begin errors++; $display("FAIL rep_total: got %h expected %h", q, REP ? 16'h0007 : 16'h0001); end
    endtask

    task automatic test_divider;
        logic v [17];
        int   tog;
        tog = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            v[k] = clk_div;
            clr = (k % 3 == 0);
            btn_down = (k >= 2 && k < 9);
            if (k >= 2) begin
                checks++;
                if (v[k] !== ~v[k-2]) begin errors++; $display("FAIL div_half_%0d: got %b expected %b", k, v[k], ~v[k-2]); end
            end
            if (k >= 1 && v[k] !== v[k-1]) tog++;
        end
        clr = 1'b0;
        btn_down = 1'b0;
        checks++;
        if (tog != 8) begin errors++; $display("FAIL div_toggles: got %0d expected 8", tog); end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        do_clr();
        for (int i = 0; i < 437; i++) press(1'b0, n);
        checks++;
        if (q !== 16'h0437) begin errors++; $display("FAIL preload_437: got %h expected 0437", q); end
        for (int i = 0; i < 8 && clk_div !== 1'b1; i++) @(negedge clk);
        checks++;
        if (clk_div !== 1'b1) begin errors++; $display("FAIL div_wait: got %b expected 1", clk_div); end
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (q !== 16'h0000) begin errors++; $display("FAIL async_q: got %h expected 0000", q); end
        if (clk_div !== 1'b0) begin errors++; $display("FAIL async_div: got %b expected 0", clk_div); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL async_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 5) btn_up = 1'b0;
            if (k == 6) begin
                checks++;
                if (q !== 16'h0000) begin errors++; $display("FAIL redeb_early: got %h expected 0000", q); end
            end
            if (k == 7) begin
                checks++;
                if (q !== 16'h0001) begin errors++; $display("FAIL redeb_step: got %h expected 0001", q); end
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        clr      = 1'b0;
        test_reset();
        test_debounce();
        test_wrap();
        test_conflict();
        test_repeat();
        test_divider();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
